// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly, sign-magnitude Q7.8, 3-stage pipeline with valid/ready.
// Optional saturation event counter: define FFT_BUTTERFLY_SAT_COUNT_EN.

package fft_butterfly_pkg;

    typedef struct packed {
        logic [15:0] a_re;
        logic [15:0] a_im;
        logic [15:0] b_re;
        logic [15:0] b_im;
        logic [15:0] w_re;
        logic [15:0] w_im;
    } s1_t;

    typedef struct packed {
        logic signed [17:0] a_re;
        logic signed [17:0] a_im;
        logic signed [17:0] t_re;
        logic signed [17:0] t_im;
    } s2_t;

    typedef struct packed {
        logic [15:0] x_re;
        logic [15:0] x_im;
        logic [15:0] y_re;
        logic [15:0] y_im;
        logic        sat;
    } s3_t;

    function automatic logic signed [17:0] sm_to_tc(
        input logic [15:0] v
    );
        logic signed [17:0] m;
        m = signed'({3'b000, v[14:0]});
        return v[15] ? -m : m;
    endfunction

    function automatic logic [17:0] tc_abs(
        input logic signed [17:0] v
    );
        return v[17] ? 18'(-v) : 18'(v);
    endfunction

    function automatic logic is_over(
        input logic signed [17:0] v,
        input logic [14:0]        lim
    );
        return tc_abs(v) > {3'b000, lim};
    endfunction

    // Zero magnitude always leaves as +0, so -0 never escapes.
    function automatic logic [15:0] tc_to_sm_sat(
        input logic signed [17:0] v,
        input logic [14:0]        lim
    );
        logic [17:0] mag;
        logic [14:0] m;
        mag = tc_abs(v);
        unique case (1'b1)
            (mag > {3'b000, lim}): m = lim;
            default:               m = mag[14:0];
        endcase
        return (m == 15'd0) ? 16'h0000 : {v[17], m};
    endfunction

endpackage

module fixed_point_math (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic [29:0] mag_prod;
    logic        unused_prod;

    assign mag_prod = {15'd0, a[14:0]} * {15'd0, b[14:0]};
    // Upper product bits wrap away by design.
    assign p = {a[15] ^ b[15], mag_prod[22:8]};
    assign unused_prod = ^{mag_prod[29:23], mag_prod[7:0]};

endmodule

module fft_butterfly_stage
    import fft_butterfly_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter logic [15:0] SAT_MAG = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_re,
    input  logic [15:0] a_im,
    input  logic [15:0] b_re,
    input  logic [15:0] b_im,
    input  logic [15:0] w_re,
    input  logic [15:0] w_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_re,
    output logic [15:0] x_im,
    output logic [15:0] y_re,
    output logic [15:0] y_im,
    output logic [15:0] sat_count
);

    localparam logic [14:0] SAT_LIM = SAT_MAG[14:0];

    if (LATENCY != 3 || SAT_MAG[15]) begin : g_bad_param
        $error("fft_butterfly_stage: LATENCY must be 3, SAT_MAG 15 bits");
    end

    logic en;
    s1_t  s1_d;
    s1_t  s1_q;
    logic s1_v;
    s2_t  s2_d;
    s2_t  s2_q;
    logic s2_v;
    s3_t  s3_d;

    logic [15:0] p_rr;
    logic [15:0] p_ii;
    logic [15:0] p_ri;
    logic [15:0] p_ir;

    logic signed [17:0] sum_xr;
    logic signed [17:0] sum_xi;
    logic signed [17:0] sum_yr;
    logic signed [17:0] sum_yi;

    // Whole pipeline advances together; output stall freezes everything.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_d      = '0;
        s1_d.a_re = a_re;
        s1_d.a_im = a_im;
        s1_d.b_re = b_re;
        s1_d.b_im = b_im;
        s1_d.w_re = w_re;
        s1_d.w_im = w_im;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (en) begin
            s1_v <= in_valid;
            s1_q <= s1_d;
        end
    end

    fixed_point_math u_mul_rr (
        .a (s1_q.b_re),
        .b (s1_q.w_re),
        .p (p_rr)
    );

    fixed_point_math u_mul_ii (
        .a (s1_q.b_im),
        .b (s1_q.w_im),
        .p (p_ii)
    );

    fixed_point_math u_mul_ri (
        .a (s1_q.b_re),
        .b (s1_q.w_im),
        .p (p_ri)
    );

    fixed_point_math u_mul_ir (
        .a (s1_q.b_im),
        .b (s1_q.w_re),
        .p (p_ir)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.a_re = sm_to_tc(s1_q.a_re);
        s2_d.a_im = sm_to_tc(s1_q.a_im);
        s2_d.t_re = sm_to_tc(p_rr) - sm_to_tc(p_ii);
        s2_d.t_im = sm_to_tc(p_ri) + sm_to_tc(p_ir);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (en) begin
            s2_v <= s1_v;
            s2_q <= s2_d;
        end
    end

    // 18 bits holds |a| + 2*|product| without overflow.
    always_comb begin
        sum_xr    = s2_q.a_re + s2_q.t_re;
        sum_xi    = s2_q.a_im + s2_q.t_im;
        sum_yr    = s2_q.a_re - s2_q.t_re;
        sum_yi    = s2_q.a_im - s2_q.t_im;
        s3_d      = '0;
        s3_d.x_re = tc_to_sm_sat(sum_xr, SAT_LIM);
        s3_d.x_im = tc_to_sm_sat(sum_xi, SAT_LIM);
        s3_d.y_re = tc_to_sm_sat(sum_yr, SAT_LIM);
        s3_d.y_im = tc_to_sm_sat(sum_yi, SAT_LIM);
        s3_d.sat  = is_over(sum_xr, SAT_LIM) | is_over(sum_xi, SAT_LIM)
                  | is_over(sum_yr, SAT_LIM) | is_over(sum_yi, SAT_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_re      <= 16'h0000;
            x_im      <= 16'h0000;
            y_re      <= 16'h0000;
            y_im      <= 16'h0000;
        end else if (en) begin
            out_valid <= s2_v;
            x_re      <= s3_d.x_re;
            x_im      <= s3_d.x_im;
            y_re      <= s3_d.y_re;
            y_im      <= s3_d.y_im;
        end
    end

`ifdef FFT_BUTTERFLY_SAT_COUNT_EN
    logic        out_sat;
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sat <= 1'b0;
        end else if (en) begin
            out_sat <= s3_d.sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= 16'h0000;
        end else if (out_valid && out_ready && out_sat
                     && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    logic unused_sat;

    assign sat_count  = 16'h0000;
    assign unused_sat = s3_d.sat;
`endif

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Self-checking bench for fft_butterfly_stage: directed vectors plus
// randomized streams scored against an integer-arithmetic reference model.

module tb_fft_butterfly_stage;

    typedef struct packed {
        logic [15:0] a_re;
        logic [15:0] a_im;
        logic [15:0] b_re;
        logic [15:0] b_im;
        logic [15:0] w_re;
        logic [15:0] w_im;
    } smp_t;

    typedef struct packed {
        logic [15:0] x_re;
        logic [15:0] x_im;
        logic [15:0] y_re;
        logic [15:0] y_im;
        logic        sat;
    } res_t;

`ifdef FFT_BUTTERFLY_SAT_COUNT_EN
    localparam bit SATC = 1'b1;
`else
    localparam bit SATC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_re = '0;
    logic [15:0] a_im = '0;
    logic [15:0] b_re = '0;
    logic [15:0] b_im = '0;
    logic [15:0] w_re = '0;
    logic [15:0] w_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x_re;
    logic [15:0] x_im;
    logic [15:0] y_re;
    logic [15:0] y_im;
    logic [15:0] sat_count;

    int total = 0;
    int bad = 0;
    res_t exp_q[$];
    logic [15:0] exp_cnt = 16'h0000;

    always #5 clk = ~clk;

    fft_butterfly_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .y_re      (y_re),
        .y_im      (y_im),
        .sat_count (sat_count)
    );

    function automatic int sm2i(logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic int mul(logic [15:0] a, logic [15:0] b);
        longint p;
        int m;
        p = longint'(a[14:0]) * longint'(b[14:0]);
        m = int'((p / 256) % 32768);
        return (a[15] ^ b[15]) ? -m : m;
    endfunction

    function automatic logic [16:0] i2sm(int v);
        int m;
        bit ov;
        m  = (v < 0) ? -v : v;
        ov = (m > 32767);
        if (ov) m = 32767;
        if (m == 0) return 17'h0;
        return {ov, (v < 0), m[14:0]};
    endfunction

    function automatic res_t model(smp_t s);
        int tr, ti, ar, ai;
        logic [16:0] xr, xi, yr, yi;
        res_t r;
        tr = mul(s.b_re, s.w_re) - mul(s.b_im, s.w_im);
        ti = mul(s.b_re, s.w_im) + mul(s.b_im, s.w_re);
        ar = sm2i(s.a_re);
        ai = sm2i(s.a_im);
        xr = i2sm(ar + tr);
        xi = i2sm(ai + ti);
        yr = i2sm(ar - tr);
        yi = i2sm(ai - ti);
        r.x_re = xr[15:0];
        r.x_im = xi[15:0];
        r.y_re = yr[15:0];
        r.y_im = yi[15:0];
        r.sat  = xr[16] | xi[16] | yr[16] | yi[16];
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            4: return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic smp_t rnd_smp();
        smp_t s;
        s = {rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16()};
        return s;
    endfunction

    task automatic step(input bit v, input smp_t s, input bit ordy,
                        output bit acc, output bit hs, output res_t got);
        @(negedge clk);
        in_valid  = v;
        {a_re, a_im, b_re, b_im, w_re, w_im} = s;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        got = {x_re, x_im, y_re, y_im, 1'b0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        total++;
        if ({x_re, x_im, y_re, y_im} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {x_re, x_im, y_re, y_im});
        end
        total++;
        if (sat_count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_sat_count got=%h exp=0000", sat_count);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst = 1'b0;
        exp_cnt = 16'h0000;
    endtask

    task automatic test_directed();
        smp_t vs[6];
        res_t ve[6];
        bit acc, hs;
        res_t got;
        int lat;
        vs[0] = {16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000};
        ve[0] = {16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vs[1] = {16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h8100};
        ve[1] = {16'h0000, 16'h8100, 16'h0000, 16'h0100, 1'b0};
        vs[2] = {16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000};
        ve[2] = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vs[3] = {16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        ve[3] = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vs[4] = {16'h0000, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000};
        ve[4] = {16'h0100, 16'h0000, 16'h8100, 16'h0000, 1'b0};
        vs[5] = {16'hFF00, 16'h0000, 16'h7F00, 16'h0000, 16'h8100, 16'h0000};
        ve[5] = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vs[i], 1'b1, acc, hs, got);
            total++;
            if (acc !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_accept got=%b exp=1", i, acc);
            end
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                step(1'b0, vs[i], 1'b1, acc, hs, got);
                if (hs) begin
                    lat = k;
                    break;
                end
            end
            total++;
            if (lat !== 3) begin
                bad++;
                $display("FAIL dir%0d_latency got=%0d exp=3", i, lat);
            end
            total++;
            if (got[16:1] !== ve[i][16:1] || got[64:17] !== ve[i][64:17]) begin
                bad++;
                $display("FAIL dir%0d_data got=%h exp=%h", i, got[64:1], ve[i][64:1]);
            end
            if (SATC && ve[i].sat) exp_cnt++;
            step(1'b0, vs[i], 1'b1, acc, hs, got);
            total++;
            if (sat_count !== exp_cnt) begin
                bad++;
                $display("FAIL dir%0d_sat_count got=%h exp=%h", i, sat_count, exp_cnt);
            end
        end
    endtask

    task automatic test_random();
        bit acc, hs;
        res_t got, e;
        smp_t s;
        bit v, r;
        for (int n = 0; n < 420; n++) begin
            s = rnd_smp();
            v = (n < 400) && ($urandom_range(0, 3) != 0);
            r = (n >= 400) || ($urandom_range(0, 9) < 7);
            step(v, s, r, acc, hs, got);
            total++;
            if (sat_count !== exp_cnt) begin
                bad++;
                $display("FAIL rnd_sat_count n=%0d got=%h exp=%h", n, sat_count, exp_cnt);
            end
            if (hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra n=%0d got=%h exp=none", n, got[64:1]);
                end else begin
                    e = exp_q.pop_front();
                    if (got[64:1] !== e[64:1]) begin
                        bad++;
                        $display("FAIL rnd_data n=%0d got=%h exp=%h", n, got[64:1], e[64:1]);
                    end
                    if (SATC && e.sat && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            if (acc) exp_q.push_back(model(s));
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rnd_drain got=%0d left exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit acc, hs;
        res_t got, e, held;
        smp_t s[8];
        int i, nout;
        bit r;
        for (int k = 0; k < 8; k++) s[k] = rnd_smp();
        i = 0;
        nout = 0;
        held = '0;
        for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
            r = !(cyc >= 5 && cyc < 10);
            step(i < 8, (i < 8) ? s[i] : s[0], r, acc, hs, got);
            if (!r) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_stall_ready cyc=%0d got=%b%b exp=01", cyc, in_ready, out_valid);
                end
                if (cyc == 5) begin
                    held = got;
                end else begin
                    total++;
                    if (got !== held) begin
                        bad++;
                        $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, got[64:1], held[64:1]);
                    end
                end
            end
            if (hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra cyc=%0d got=%h exp=none", cyc, got[64:1]);
                end else begin
                    e = exp_q.pop_front();
                    if (got[64:1] !== e[64:1]) begin
                        bad++;
                        $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, got[64:1], e[64:1]);
                    end
                    if (SATC && e.sat && exp_cnt != 16'hFFFF) exp_cnt++;
                end
                nout++;
            end
            if (acc) begin
                exp_q.push_back(model(s[i]));
                i++;
            end
        end
        total++;
        if (nout != 8 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count got=%0d out %0d left exp=8 out 0 left", nout, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit acc, hs;
        res_t got;
        int nout;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, rnd_smp(), 1'b1, acc, hs, got);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_out_valid got=%b exp=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_in_ready got=%b exp=1", in_ready);
        end
        total++;
        if (sat_count !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_sat_count got=%h exp=0000", sat_count);
        end
        nout = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, rnd_smp(), 1'b1, acc, hs, got);
            if (hs) nout++;
        end
        total++;
        if (nout != 0) begin
            bad++;
            $display("FAIL midrst_stale got=%0d exp=0", nout);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_stage.md
Name: fft_butterfly_stage

Overview:
- Pipelined radix-2 decimation-in-time butterfly for the FFT datapath.
- Sits directly downstream of the sign-magnitude Q7.8 multiplier (fixed_point_math). It instantiates four copies of that multiplier to form the twiddle product W*B, then computes X = A + W*B and Y = A - W*B.
- All external data is 16-bit sign-magnitude Q7.8: bit 15 is the sign, bits 14:8 are integer, bits 7:0 are fraction.
- Valid/ready handshake on both sides; feeds the FFT reorder/memory stage.

Parameters:
- LATENCY, 3, pipeline depth in cycles. Fixed; any other value is illegal.
- SAT_MAG, 16'h7FFF, saturation magnitude. Must fit in 15 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  stage can accept a sample
- a_re, a_im  in  16 each  operand A, sign-magnitude Q7.8
- b_re, b_im  in  16 each  operand B, sign-magnitude Q7.8
- w_re, w_im  in  16 each  twiddle W, sign-magnitude Q7.8
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- x_re, x_im  out  16 each  X = A + W*B, sign-magnitude Q7.8
- y_re, y_im  out  16 each  Y = A - W*B, sign-magnitude Q7.8
- sat_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset: on rst=1 at a clk edge, all stage valids and out_valid go 0, all data outputs go 16'h0000, sat_count goes 0. Reset mid-operation discards in-flight samples. in_ready is 1 the cycle after reset.
- Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en, combinational.
  - When en=0 the whole pipeline holds; outputs stay stable while out_valid=1 && out_ready=0.
- A sample is accepted when in_valid && in_ready. Its result appears with out_valid=1 exactly 3 enabled cycles later. Back-to-back throughput is 1 sample per cycle; bubbles propagate as valid=0.
- Stage 1:
  - Register A, B and W.
  - Four multipliers form br*wr, bi*wi, br*wi, bi*wr.
  - Multiplier rule, which the bench model must match exactly:
    - sign = XOR of the input signs;
    - magnitude = bits [22:8] of the 30-bit magnitude product;
    - higher bits are silently discarded (wraps, no saturation).
- Stage 2:
  - Convert products and A to 18-bit two's complement. Sign-magnitude negative zero converts to 0.
  - t_re = br*wr - bi*wi; t_im = br*wi + bi*wr. Register t and A.
- Stage 3:
  - x = a + t, y = a - t, all in 18-bit two's complement.
  - Saturate each component to [-32767, +32767].
  - Convert back to sign-magnitude. A zero result is always emitted as 16'h0000, never 16'h8000.
  - Register the outputs.
- Saturation flag for a sample = OR over the four components of (pre-saturation |value| > 32767).
- Simultaneous accept and output in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: FFT_BUTTERFLY_SAT_COUNT_EN.
- Defined:
  - sat_count increments by 1 on each output handshake (out_valid && out_ready) whose sample had the saturation flag set.
  - It saturates at 16'hFFFF and clears on rst.
- Undefined: sat_count is tied to 16'h0000 and no counter logic is built.

Test Plan:
- A=(0x0100,0), B=(0x0100,0), W=(0x0100,0), out_ready=1 -> 3 cycles later X=(0x0200,0x0000), Y=(0x0000,0x0000).
- A=0, B=(0x0100,0), W=(0x0000,0x8100) -> X=(0x0000,0x8100), Y=(0x0000,0x0100).
- A=(0x7F00,0), B=(0x7F00,0), W=(0x0100,0) -> X re=0x7FFF, Y re=0x0000. With macro defined, sat_count=1 after the handshake.
- Negative-zero inputs: A=(0x8000,0x8000), B=0, W=0 -> X=Y=(0x0000,0x0000).
- Stream 8 samples back-to-back, then hold out_ready=0 for 5 cycles mid-stream:
  - in_ready drops within the same cycle;
  - outputs hold stable;
  - all 8 results emerge in order, with none lost or duplicated.
- Assert rst with 3 samples in flight -> out_valid=0 the next cycle, no stale result emerges, sat_count=0, in_ready=1.
